// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in, serial-out transmitter feeding serial-in shift-register chains.
// A WIDTH-bit word is taken over a valid/ready handshake and emitted one bit
// per clock, MSB first, so a downstream chain shifting toward its output holds
// the word in natural order after the frame completes. A new word can be
// accepted on the final bit cycle of the current frame, which gives
// back-to-back frames with no idle gap.
//
// Optional build macro: SERIALIZER_PARITY_EN
//   When defined, each frame carries one extra trailing even-parity bit
//   (XOR of the accepted word) and frame_last marks that parity cycle.
//
// Parameters:
//   WIDTH        data word width in bits (2..32)
//
// Ports:
//   clock        single clock, all state updates on its rising edge
//   reset        synchronous active-high reset
//   load_valid   upstream presents a word on load_data
//   load_data    parallel word, sampled only on an accepting edge
//   load_ready   block can accept a word this cycle
//   shift_out    serial data bit
//   shift_valid  shift_out carries a frame bit this cycle
//   frame_last   high during the final bit cycle of a frame
// ---------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             shift_out,
    output logic             shift_valid,
    output logic             frame_last
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // The counter is loaded with the number of bit cycles remaining after the
    // first one; the parity build has one extra cycle per frame.
`ifdef SERIALIZER_PARITY_EN
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
`else
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] bit_cnt;
    logic             accept;

`ifdef SERIALIZER_PARITY_EN
    logic             parity_bit;

    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction
`endif

    // All outputs decode registered state only; load_ready additionally
    // depends on reset so that nothing is accepted while reset is held.
    assign frame_last  = (state == SHIFT) && (bit_cnt == '0);
    assign load_ready  = !reset && ((state == IDLE) || frame_last);
    assign accept      = load_valid && load_ready;
    assign shift_valid = (state == SHIFT);

`ifdef SERIALIZER_PARITY_EN
    // Data bits come from the MSB of the shifter; the counter reaching zero
    // marks the trailing parity cycle.
    assign shift_out = (state == SHIFT) &&
                       ((bit_cnt == '0) ? parity_bit : sreg[WIDTH-1]);
`else
    assign shift_out = (state == SHIFT) && sreg[WIDTH-1];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
`ifdef SERIALIZER_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (accept) begin
            // Accept takes priority over the frame_last -> IDLE transition,
            // which is what makes back-to-back frames gapless.
            state   <= SHIFT;
            sreg    <= load_data;
            bit_cnt <= CNT_LOAD;
`ifdef SERIALIZER_PARITY_EN
            parity_bit <= even_parity(load_data);
`endif
        end else if (state == SHIFT) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
            if (bit_cnt == '0) begin
                state <= IDLE;
            end else begin
                bit_cnt <= bit_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//
// Self-checking bench for piso_serializer. A negedge monitor holds a queue of
// expected serial bits: every accepted word (as predicted by the bench's own
// handshake model) pushes its bits, and every cycle pops and compares the
// DUT's serial outputs and load_ready against the head of that queue.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int WIDTH = 8;
`ifdef SERIALIZER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FRAME = WIDTH + (PAR ? 1 : 0);

    logic             clock;
    logic             reset;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             shift_out;
    logic             shift_valid;
    logic             frame_last;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    exp_t q[$];
    exp_t h, e;
    logic ev, eb, el, er;

    int   checks      = 0;
    int   errors      = 0;
    int   acc_cnt     = 0;
    int   valid_cycles = 0;
    int   run         = 0;
    int   max_run     = 0;
    logic last_bit    = 1'b0;
    bit   mon_en      = 1'b0;

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .shift_out  (shift_out),
        .shift_valid(shift_valid),
        .frame_last (frame_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard monitor: compare, pop, then predict the next edge.
    always @(negedge clock) begin
        if (mon_en) begin
            ev = (q.size() != 0);
            eb = 1'b0;
            el = 1'b0;
            if (ev) begin
                h  = q[0];
                eb = h.b;
                el = h.last;
            end
            er = !reset && (!ev || el);

            checks++;
            if (shift_valid !== ev) begin
                errors++;
                $display("FAIL shift_valid t=%0t got %b expected %b", $time, shift_valid, ev);
            end
            checks++;
            if (shift_out !== eb) begin
                errors++;
                $display("FAIL shift_out t=%0t got %b expected %b", $time, shift_out, eb);
            end
            checks++;
            if (frame_last !== el) begin
                errors++;
                $display("FAIL frame_last t=%0t got %b expected %b", $time, frame_last, el);
            end
            checks++;
            if (load_ready !== er) begin
                errors++;
                $display("FAIL load_ready t=%0t got %b expected %b", $time, load_ready, er);
            end

            if (shift_valid === 1'b1) begin
                valid_cycles++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (frame_last === 1'b1) last_bit = shift_out;

            if (ev) void'(q.pop_front());
            if (reset) begin
                q.delete();
            end else if (load_valid && er) begin
                acc_cnt++;
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    e.b    = load_data[i];
                    e.last = !PAR && (i == 0);
                    q.push_back(e);
                end
                if (PAR) begin
                    e.b    = ^load_data;
                    e.last = 1'b1;
                    q.push_back(e);
                end
            end
        end
    end

    // Present a word and hold it until the handshake model sees it accepted.
    task automatic send(input logic [WIDTH-1:0] w);
        int start;
        bit done;
        start      = acc_cnt;
        done       = 1'b0;
        load_valid = 1'b1;
        load_data  = w;
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge clock); #1;
            if (acc_cnt != start) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout word=%h got no accept expected accept within 50 cycles", w);
        end
        load_valid = 1'b0;
        load_data  = WIDTH'($urandom);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clock); #1;
            if (q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout got %0d pending bits expected 0", q.size());
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'hA5;
        @(posedge clock); #1;
        mon_en = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
        end
        reset      = 1'b0;
        load_valid = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
        end
        checks++;
        if (acc_cnt !== 0) begin
            errors++;
            $display("FAIL reset_no_capture got %0d accepts expected 0", acc_cnt);
        end
        checks++;
        if (shift_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got shift_valid=%b expected 0", shift_valid);
        end
    endtask

    task automatic test_single(input logic [WIDTH-1:0] w);
        int v0;
        logic exp_last;
        exp_last = PAR ? ^w : w[0];
        v0 = valid_cycles;
        send(w);
        wait_idle();
        checks++;
        if (valid_cycles - v0 !== FRAME) begin
            errors++;
            $display("FAIL frame_len word=%h got %0d expected %0d", w, valid_cycles - v0, FRAME);
        end
        checks++;
        if (last_bit !== exp_last) begin
            errors++;
            $display("FAIL final_bit word=%h got %b expected %b", w, last_bit, exp_last);
        end
        checks++;
        if (load_ready !== 1'b1 || shift_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_frame_idle got ready=%b valid=%b expected ready=1 valid=0",
                     load_ready, shift_valid);
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        int start;
        bit done;
        v0 = valid_cycles;
        max_run = 0;
        send(8'hA5);
        // Keep valid high with the next word; it must be taken on frame_last.
        start      = acc_cnt;
        done       = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'h3C;
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge clock); #1;
            if (acc_cnt != start) done = 1'b1;
        end
        load_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL b2b_accept got no accept expected accept of 3C");
        end
        wait_idle();
        checks++;
        if (valid_cycles - v0 !== 2 * FRAME) begin
            errors++;
            $display("FAIL b2b_len got %0d expected %0d", valid_cycles - v0, 2 * FRAME);
        end
        checks++;
        if (max_run !== 2 * FRAME) begin
            errors++;
            $display("FAIL b2b_gapless got run %0d expected %0d", max_run, 2 * FRAME);
        end
    endtask

    task automatic test_ignore_busy();
        int start;
        send(8'hFF);
        start = acc_cnt;
        @(posedge clock); #1;
        for (int i = 0; i < 5; i++) begin
            load_valid = i[0];
            load_data  = 8'h00;
            @(posedge clock); #1;
        end
        checks++;
        if (acc_cnt !== start) begin
            errors++;
            $display("FAIL busy_ignore got %0d accepts expected 0", acc_cnt - start);
        end
        send(8'h00);
        wait_idle();
        checks++;
        if (acc_cnt !== start + 1) begin
            errors++;
            $display("FAIL busy_reaccept got %0d accepts expected 1", acc_cnt - start);
        end
    endtask

    task automatic test_reset_abort();
        int v0;
        send(8'hF0);
        // Now in bit 1; advance through bits 2 and 3, reset during bit 4.
        repeat (3) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++;
        if (shift_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_valid got %b expected 0", shift_valid);
        end
        repeat (2) begin
            @(posedge clock); #1;
        end
        v0 = valid_cycles;
        send(8'h81);
        wait_idle();
        checks++;
        if (valid_cycles - v0 !== FRAME) begin
            errors++;
            $display("FAIL abort_next_len got %0d expected %0d", valid_cycles - v0, FRAME);
        end
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        test_reset();
        test_single(8'hA5);
        test_back_to_back();
        test_ignore_busy();
        test_reset_abort();
        test_single(8'h07);
        test_single(8'h5A);
`ifdef SERIALIZER_PARITY_EN
        test_single(8'h00);
        test_single(8'hFE);
`endif
        repeat (2) begin
            @(posedge clock); #1;
        end
        checks++;
        if (q.size() !== 0) begin
            errors++;
            $display("FAIL drain got %0d pending bits expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
